// File: rtl/velocity_pkg.sv
// Shared widths, defaults and the bank-index type for the velocity ping-pong buffer.
package velocity_pkg;

    localparam int COMP_WIDTH       = 32;
    localparam int DATA_WIDTH_DEF   = 3 * COMP_WIDTH;
    localparam int PARTICLE_NUM_DEF = 220;
    localparam int ADDR_WIDTH_DEF   = 8;

    typedef logic bank_t;

endpackage

// File: rtl/cell_ram_sdp.sv
// Simple dual-port cell RAM: one write port, one read port with a registered output.
module cell_ram_sdp #(
    parameter int DATA_WIDTH = 96,
    parameter int DEPTH      = 220,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    (* ramstyle = "M20K" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: no reset here; a reset port would stop the array mapping onto block RAM.
    // Stale contents stay invisible because the reader masks anything above the count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/velocity_cell_pingpong.sv
// Two-bank velocity buffer: reads come from the active bank while updates append to the shadow bank.
module velocity_cell_pingpong
    import velocity_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int PARTICLE_NUM = PARTICLE_NUM_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  swap_req,
    output logic                  active_bank,
    output logic [ADDR_WIDTH-1:0] active_count,
    output logic [ADDR_WIDTH-1:0] shadow_count,
    output logic                  full,
    output logic                  overflow
);

    bank_t                 act_bank;
    logic                  append_ok;
    logic                  rd_hit;
    logic [DATA_WIDTH-1:0] bank_q [2];

    // Read-side context captured with each request so the output mux lines up with the RAM latency.
    bank_t                 rd_sel;
    logic                  rd_hdr;
    logic                  rd_zero;
    logic [ADDR_WIDTH-1:0] rd_count;

    assign active_bank = act_bank;
    assign full        = (shadow_count == ADDR_WIDTH'(PARTICLE_NUM - 1));
    assign append_ok   = wr_en && !full;
    assign rd_hit      = (rd_addr != '0) && (rd_addr <= active_count);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        cell_ram_sdp #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (PARTICLE_NUM),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ram (
            .clk   (clk),
            .we    (append_ok && (act_bank != bank_t'(b))),
            .waddr (shadow_count + ADDR_WIDTH'(1)),
            .wdata (wr_data),
            .re    (rd_en && rd_hit && (act_bank == bank_t'(b))),
            .raddr (rd_addr),
            .rdata (bank_q[b])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_bank     <= 1'b0;
            active_count <= '0;
            shadow_count <= '0;
            overflow     <= 1'b0;
        end else if (swap_req) begin
            // A same-cycle append lands in the bank that is about to become active.
            act_bank     <= ~act_bank;
            active_count <= shadow_count + ADDR_WIDTH'(append_ok);
            shadow_count <= '0;
            overflow     <= 1'b0;
        end else begin
            if (append_ok) begin
                shadow_count <= shadow_count + ADDR_WIDTH'(1);
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_sel   <= 1'b0;
            rd_hdr   <= 1'b0;
            rd_zero  <= 1'b1;
            rd_count <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_sel   <= act_bank;
                rd_hdr   <= (rd_addr == '0);
                rd_zero  <= (rd_addr != '0) && !rd_hit;
                rd_count <= active_count;
            end
        end
    end

    // NOTE: rd_data gets a default before the branches so no path leaves it unassigned (no latch).
    always_comb begin
        rd_data = '0;
        if (rd_zero) begin
            rd_data = '0;
        end else if (rd_hdr) begin
            rd_data = {{(DATA_WIDTH - ADDR_WIDTH){1'b0}}, rd_count};
        end else begin
            rd_data = bank_q[rd_sel];
        end
    end

endmodule

// File: tb/tb_velocity_cell_pingpong.sv
// Self-checking bench: directed scenarios plus a randomized run against a queue-based model.
module tb_velocity_cell_pingpong;

    localparam int DW = 96;
    localparam int PN = 220;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          swap_req = 1'b0;
    logic          active_bank;
    logic [AW-1:0] active_count;
    logic [AW-1:0] shadow_count;
    logic          full;
    logic          overflow;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: each bank is just an ordered list of particles.
    logic [DW-1:0] act_q [$];
    logic [DW-1:0] shd_q [$];
    logic          m_bank;
    logic          m_ovf;
    logic          m_rd_valid;
    logic [DW-1:0] m_rd_data;

    velocity_cell_pingpong #(
        .DATA_WIDTH   (DW),
        .PARTICLE_NUM (PN),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .active_bank  (active_bank),
        .active_count (active_count),
        .shadow_count (shadow_count),
        .full         (full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand96();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic logic [DW-1:0] model_read(int addr);
        if (addr == 0) return DW'(act_q.size());
        if (addr <= act_q.size()) return act_q[addr-1];
        return '0;
    endfunction

    task automatic model_reset();
        act_q.delete();
        shd_q.delete();
        m_bank     = 1'b0;
        m_ovf      = 1'b0;
        m_rd_valid = 1'b0;
        m_rd_data  = '0;
    endtask

    // Advance the model with the inputs currently driven, then let the DUT take one edge.
    task automatic tick();
        m_rd_valid = rd_en;
        if (rd_en) m_rd_data = model_read(int'(rd_addr));
        if (wr_en) begin
            if (shd_q.size() < PN - 1) shd_q.push_back(wr_data);
            else m_ovf = 1'b1;
        end
        if (swap_req) begin
            act_q = shd_q;
            shd_q.delete();
            m_ovf  = 1'b0;
            m_bank = ~m_bank;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rd_en = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_vec++; if (rd_data !== '0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_vec++; if (active_bank !== 1'b0) begin n_err++; $display("FAIL reset_bank: got %b want 0", active_bank); end
        n_vec++; if (active_count !== '0 || shadow_count !== '0) begin n_err++; $display("FAIL reset_counts: got %0d/%0d want 0/0", active_count, shadow_count); end
        n_vec++; if (full !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL reset_flags: got full=%b ovf=%b want 0/0", full, overflow); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] w [3];
        logic [DW-1:0] exp_v [5];
        for (int i = 0; i < 3; i++) w[i] = rand96();
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin wr_data = w[i]; tick(); end
        wr_en = 1'b0;
        n_vec++; if (shadow_count !== 8'd3) begin n_err++; $display("FAIL basic_shadow_count: got %0d want 3", shadow_count); end
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        n_vec++; if (active_count !== 8'd3 || shadow_count !== 8'd0) begin n_err++; $display("FAIL basic_swap_counts: got %0d/%0d want 3/0", active_count, shadow_count); end
        n_vec++; if (active_bank !== 1'b1) begin n_err++; $display("FAIL basic_bank: got %b want 1", active_bank); end
        exp_v[0] = DW'(3); exp_v[1] = w[0]; exp_v[2] = w[1]; exp_v[3] = w[2]; exp_v[4] = '0;
        for (int a = 0; a < 5; a++) begin
            rd_en = 1'b1; rd_addr = AW'(a); tick();
            n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid addr %0d: got %b want 1", a, rd_valid); end
            n_vec++; if (rd_data !== exp_v[a]) begin n_err++; $display("FAIL basic_read addr %0d: got %h want %h", a, rd_data, exp_v[a]); end
        end
        rd_addr = 8'd2; tick();
        rd_en = 1'b0; tick(); tick();
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_idle: got %b want 0", rd_valid); end
        n_vec++; if (rd_data !== w[1]) begin n_err++; $display("FAIL basic_hold: got %h want %h", rd_data, w[1]); end
    endtask

    task automatic test_full_overflow();
        logic [DW-1:0] w [PN-1];
        wr_en = 1'b1;
        for (int i = 0; i < PN - 1; i++) begin
            w[i] = rand96(); wr_data = w[i]; tick();
            if (i == PN - 3) begin
                n_vec++; if (full !== 1'b0 || shadow_count !== 8'd218) begin n_err++; $display("FAIL fill_218: got full=%b cnt=%0d want 0/218", full, shadow_count); end
            end
        end
        n_vec++; if (full !== 1'b1 || shadow_count !== 8'd219) begin n_err++; $display("FAIL fill_219: got full=%b cnt=%0d want 1/219", full, shadow_count); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_no_ovf: got %b want 0", overflow); end
        wr_data = rand96(); tick(); wr_en = 1'b0;
        n_vec++; if (overflow !== 1'b1 || shadow_count !== 8'd219) begin n_err++; $display("FAIL drop_220: got ovf=%b cnt=%0d want 1/219", overflow, shadow_count); end
        tick();
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        n_vec++; if (overflow !== 1'b0 || active_count !== 8'd219 || full !== 1'b0) begin n_err++; $display("FAIL full_swap: got ovf=%b act=%0d full=%b want 0/219/0", overflow, active_count, full); end
        rd_en = 1'b1; rd_addr = 8'd219; tick();
        n_vec++; if (rd_data !== w[PN-2]) begin n_err++; $display("FAIL read_219: got %h want %h", rd_data, w[PN-2]); end
        rd_addr = 8'd220; tick(); rd_en = 1'b0;
        n_vec++; if (rd_data !== '0 || rd_valid !== 1'b1) begin n_err++; $display("FAIL read_220: got %h v=%b want 0 v=1", rd_data, rd_valid); end
    endtask

    task automatic test_swap_collision();
        logic [DW-1:0] d;
        wr_en = 1'b1;
        wr_data = rand96(); tick();
        wr_data = rand96(); tick();
        wr_en = 1'b0; swap_req = 1'b1; tick(); swap_req = 1'b0;
        n_vec++; if (active_count !== 8'd2) begin n_err++; $display("FAIL coll_setup: got %0d want 2", active_count); end
        d = rand96();
        wr_en = 1'b1; wr_data = d; swap_req = 1'b1; rd_en = 1'b1; rd_addr = 8'd0;
        tick();
        wr_en = 1'b0; swap_req = 1'b0;
        n_vec++; if (rd_data !== DW'(2) || rd_valid !== 1'b1) begin n_err++; $display("FAIL coll_pre_swap_read: got %h v=%b want 2 v=1", rd_data, rd_valid); end
        n_vec++; if (active_count !== 8'd1 || shadow_count !== 8'd0) begin n_err++; $display("FAIL coll_counts: got %0d/%0d want 1/0", active_count, shadow_count); end
        rd_addr = 8'd1; tick();
        n_vec++; if (rd_data !== d) begin n_err++; $display("FAIL coll_read_d: got %h want %h", rd_data, d); end
        rd_addr = 8'd2; tick(); rd_en = 1'b0;
        n_vec++; if (rd_data !== '0) begin n_err++; $display("FAIL coll_stale_masked: got %h want 0", rd_data); end
    endtask

    task automatic test_back_to_back();
        logic b0;
        b0 = m_bank;
        wr_en = 1'b1; wr_data = rand96(); tick(); wr_en = 1'b0;
        swap_req = 1'b1; tick();
        n_vec++; if (active_count !== 8'd1 || active_bank !== ~b0) begin n_err++; $display("FAIL b2b_first: got cnt=%0d bank=%b want 1/%b", active_count, active_bank, ~b0); end
        tick(); swap_req = 1'b0;
        n_vec++; if (active_bank !== b0) begin n_err++; $display("FAIL b2b_bank: got %b want %b", active_bank, b0); end
        n_vec++; if (active_count !== 8'd0) begin n_err++; $display("FAIL b2b_count: got %0d want 0", active_count); end
    endtask

    task automatic test_reset_mid_fill();
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin wr_data = rand96(); tick(); end
        wr_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        n_vec++; if (shadow_count !== '0 || active_count !== '0 || active_bank !== 1'b0) begin n_err++; $display("FAIL midrst_state: got sh=%0d act=%0d bank=%b want 0/0/0", shadow_count, active_count, active_bank); end
        n_vec++; if (rd_valid !== 1'b0 || rd_data !== '0 || full !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL midrst_outputs: got v=%b d=%h f=%b o=%b want zeros", rd_valid, rd_data, full, overflow); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        n_vec++; if (active_count !== '0 || active_bank !== 1'b1) begin n_err++; $display("FAIL midrst_swap: got cnt=%0d bank=%b want 0/1", active_count, active_bank); end
        rd_en = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd_addr = AW'(a); tick();
            n_vec++; if (rd_data !== '0 || rd_valid !== 1'b1) begin n_err++; $display("FAIL midrst_read addr %0d: got %h v=%b want 0 v=1", a, rd_data, rd_valid); end
        end
        rd_en = 1'b0; tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            rd_en = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) rd_addr = AW'($urandom_range(0, 255));
            else rd_addr = AW'($urandom_range(0, act_q.size() + 1));
            wr_en    = ($urandom_range(0, 3) != 0);
            wr_data  = rand96();
            swap_req = ($urandom_range(0, 299) == 0);
            tick();
            n_vec++; if (rd_valid !== m_rd_valid) begin n_err++; $display("FAIL rand_rd_valid cyc %0d: got %b want %b", c, rd_valid, m_rd_valid); end
            n_vec++; if (rd_data !== m_rd_data) begin n_err++; $display("FAIL rand_rd_data cyc %0d: got %h want %h", c, rd_data, m_rd_data); end
            n_vec++; if (active_bank !== m_bank) begin n_err++; $display("FAIL rand_bank cyc %0d: got %b want %b", c, active_bank, m_bank); end
            n_vec++; if (active_count !== AW'(act_q.size())) begin n_err++; $display("FAIL rand_active_count cyc %0d: got %0d want %0d", c, active_count, act_q.size()); end
            n_vec++; if (shadow_count !== AW'(shd_q.size())) begin n_err++; $display("FAIL rand_shadow_count cyc %0d: got %0d want %0d", c, shadow_count, shd_q.size()); end
            n_vec++; if (full !== (shd_q.size() == PN - 1)) begin n_err++; $display("FAIL rand_full cyc %0d: got %b want %b", c, full, shd_q.size() == PN - 1); end
            n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rand_overflow cyc %0d: got %b want %b", c, overflow, m_ovf); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_overflow();
        test_swap_collision();
        test_back_to_back();
        test_reset_mid_fill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/velocity_cell_pingpong.md
VELOCITY_CELL_PINGPONG -- requirements
Module: velocity_cell_pingpong

Interface
REQ-001 Parameter DATA_WIDTH, default 96, meaning one velocity word {vz, vy, vx}, 32 bits each.
REQ-002 Parameter PARTICLE_NUM, default 220, meaning words per bank; address 0 is the count header, so the bank holds at most PARTICLE_NUM-1 particles.
REQ-003 Parameter ADDR_WIDTH, default 8, meaning the read address width; ADDR_WIDTH SHALL satisfy 2**ADDR_WIDTH >= PARTICLE_NUM.
REQ-004 Port clk, input, 1, meaning the single clock; all state SHALL change on its rising edge.
REQ-005 Port rst, input, 1, meaning an asynchronous, active-low reset.
REQ-006 Port rd_en, input, 1, meaning a read request to the active bank.
REQ-007 Port rd_addr, input, ADDR_WIDTH, meaning the read address; 0 selects the header and k selects particle k.
REQ-008 Port rd_data, output, DATA_WIDTH, meaning the read result.
REQ-009 Port rd_valid, output, 1, meaning rd_data is valid.
REQ-010 Port wr_en, input, 1, meaning an append of wr_data to the shadow bank.
REQ-011 Port wr_data, input, DATA_WIDTH, meaning the updated velocity to append.
REQ-012 Port swap_req, input, 1, meaning a single-cycle pulse that exchanges the active and shadow banks.
REQ-013 Port active_bank, output, 1, meaning the index of the bank currently readable.
REQ-014 Port active_count, output, ADDR_WIDTH, meaning the particle count of the active bank.
REQ-015 Port shadow_count, output, ADDR_WIDTH, meaning the number of particles appended to the shadow bank so far.
REQ-016 Port full, output, 1, meaning shadow_count == PARTICLE_NUM-1.
REQ-017 Port overflow, output, 1, meaning sticky: an append was dropped since the last swap.

Function
REQ-018 Read latency SHALL be 1 cycle: rd_valid is high exactly in the cycle after each cycle in which rd_en is high.
REQ-019 rd_addr 0 SHALL return active_count zero-extended to DATA_WIDTH.
REQ-020 rd_addr in the range 1..active_count SHALL return the stored word.
REQ-021 rd_addr above active_count SHALL return all zeros with rd_valid still asserted.
REQ-022 When rd_en is low, rd_data SHALL hold its previous value.
REQ-023 An append with wr_en high and full low SHALL write address shadow_count+1 of the shadow bank and increment shadow_count.
REQ-024 An append with wr_en high and full high SHALL leave the bank contents unchanged, leave shadow_count unchanged, and set overflow.
REQ-025 Reads and appends SHALL proceed in the same cycle without stalling either one; the two banks are independent.
REQ-026 On swap_req, at the next edge: active_bank toggles, active_count loads shadow_count, shadow_count clears to 0, and overflow clears.
REQ-027 If wr_en and swap_req are high in the same cycle, the append SHALL be applied first and counted in the new active_count; a dropped append in that cycle does not survive, because the swap clears overflow.
REQ-028 If rd_en and swap_req are high in the same cycle, the read SHALL be served from the pre-swap active bank and active_count.
REQ-029 Two consecutive swap_req cycles SHALL produce two swaps; the second swap makes active_count 0 unless an append occurred between them.
REQ-030 Stale shadow-bank data above shadow_count SHALL never be visible, because REQ-021 masks it.

Reset
REQ-031 Asserting rst SHALL immediately force: active_bank=0, active_count=0, shadow_count=0, full=0, overflow=0, rd_valid=0, rd_data=0.
REQ-032 RAM contents are not reset; after reset both banks read as empty through the masking of REQ-021.
REQ-033 Reset asserted mid-fill SHALL discard the in-progress shadow fill.
REQ-034 Reset deasserted SHALL allow normal operation from the first clk edge.

Structure
REQ-035 The shared package velocity_pkg SHALL hold: the component width (32), the DATA_WIDTH default, the PARTICLE_NUM default, and the bank-index type.
REQ-036 One sub-module, cell_ram_sdp (simple dual-port, registered read, DATA_WIDTH x PARTICLE_NUM, M20K hint), SHALL be instantiated twice, one per bank.
REQ-037 Bank select, the header mux and the zero mask SHALL be implemented in velocity_cell_pingpong.

Verification
REQ-038 Reset, append 3 words A,B,C, swap, read addresses 0..4 -> rd_data = 3, A, B, C, 0; rd_valid high 1 cycle after each rd_en.
REQ-039 Append 219 words -> full=1, shadow_count=219; 220th append -> overflow=1, shadow_count stays 219; swap -> overflow=0, active_count=219.
REQ-040 With 2 particles active, append D and assert swap in the same cycle, with rd_en at addr 0 in that cycle -> read returns 2; next cycle active_count=1 and addr 1 returns D.
REQ-041 Two back-to-back swap_req with no appends -> active_bank returns to its original value; active_count=0.
REQ-042 Assert rst mid-fill after 5 appends, then release and swap -> active_count=0; every read address returns 0.
REQ-043 Random reads and appends run concurrently against a scoreboard model for 10k cycles -> no mismatch.
